// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan of NUM_DIGITS active-low 7-seg digits via a shared external decoder; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: load reaches the pins within one frame plus GUARD_CYCLES; seg_o/an_o/frame_tick are registered.
// Backpressure: none; load is a fire-and-forget strobe, and the last load in a frame wins.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [3:0]              nibble_o,
    input  logic [7:0]              seg_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int D_W     = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [D_W-1:0]   D_LAST     = D_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [D_W-1:0]          d_q, d_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [7:0]              seg_d;
    logic [7:0]              seg_on;
    logic                    frame_start;

    logic [4*NUM_DIGITS-1:0] shadow_value, active_value, next_value;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, next_dp;
    logic [NUM_DIGITS-1:0]   blank;

    // A load on the frame-start edge must land in this frame, so it bypasses the shadow.
    assign next_value = load ? value   : shadow_value;
    assign next_dp    = load ? dp_mask : shadow_dp;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            lz_mask[i] = ~seen;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (frame_start) begin
            blank <= lz_mask(next_value);
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            active_value <= '0;
            active_dp    <= '0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_mask;
            end
            if (frame_start) begin
                active_value <= next_value;
                active_dp    <= next_dp;
            end
        end
    end

    // The decoder sees the upcoming digit for the whole guard, so seg_i is settled at ON entry.
    always_comb begin
        nibble_o = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (d_q == D_W'(i)) begin
                nibble_o = active_value[i*4 +: 4];
            end
        end
    end

    always_comb begin
        seg_on = blank[d_q] ? 8'hFF : seg_i;
        if (active_dp[d_q]) begin
            seg_on[7] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        an_d        = an_o;
        seg_d       = seg_o;
        frame_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                an_d  = '1;
                seg_d = 8'hFF;
                d_d   = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d     = GUARD;
                    frame_start = 1'b1;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                    an_d    = ~(NUM_DIGITS'(1) << d_q);
                    seg_d   = seg_on;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = 8'hFF;
                    if (d_q == D_LAST) begin
                        d_d         = '0;
                        frame_start = 1'b1;
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                d_d     = '0;
                an_d    = '1;
                seg_d   = 8'hFF;
            end
        endcase

        // Disable wins over everything: anodes go dark on the very next edge.
        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            d_d         = '0;
            an_d        = '1;
            seg_d       = 8'hFF;
            frame_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_q        <= '0;
            an_o       <= '1;
            seg_o      <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            an_o       <= an_d;
            seg_o      <= seg_d;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a per-cycle frame-timing model predicts pins, a monitor compares.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int G     = 2;
    localparam int DPER  = G + R;
    localparam int FRAME = N * DPER;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  nibble_o;
    logic [7:0]  seg_i;
    logic [7:0]  seg_o;
    logic [7:0]  glitch = '0;
    logic [3:0]  an_o;
    logic        frame_tick;

    always #5 clk = ~clk;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
        endcase
    endfunction

    // External decoder, with deliberate corruption outside the ON-entry sampling edge.
    assign seg_i = hex7(nibble_o) ^ glitch;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD_CYCLES(G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .value     (value),
        .dp_mask   (dp_mask),
        .nibble_o  (nibble_o),
        .seg_i     (seg_i),
        .seg_o     (seg_o),
        .an_o      (an_o),
        .frame_tick(frame_tick)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       tick;
        logic       chk_seg;
        logic [3:0] nib;
        logic       chk_nib;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: time since the last frame start, plus the value latched for this frame.
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [15:0] m_shv = '0, m_av = '0;
    logic [3:0]  m_shdp = '0, m_adp = '0;

    function automatic logic [7:0] disp(input int dig);
        logic [15:0] upper;
        logic [7:0]  s;
        logic        blank;
        upper = m_av >> (4 * dig);
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (dig > 0) && (upper == 16'h0);
`endif
        s = blank ? 8'hFF : hex7(upper[3:0]);
        if (m_adp[dig]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic step(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] dp);
        exp_t        e;
        int          slot, dig;
        logic [15:0] tmp;
        @(negedge clk);
        enable  = en;
        load    = ld;
        value   = v;
        dp_mask = dp;
        glitch  = 8'($urandom);
        e.an = 4'hF; e.seg = 8'hFF; e.tick = 1'b0; e.chk_seg = 1'b1; e.nib = 4'h0; e.chk_nib = 1'b0;
        if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            if (m_t == 0) begin
                m_av   = ld ? v : m_shv;
                m_adp  = ld ? dp : m_shdp;
                e.tick = 1'b1;
            end
            slot = m_t % DPER;
            dig  = m_t / DPER;
            if (slot < G) begin
                tmp       = m_av >> (4 * dig);
                e.nib     = tmp[3:0];
                e.chk_nib = 1'b1;
                e.chk_seg = 1'b0;
            end else begin
                e.an  = ~4'(1 << dig);
                e.seg = disp(dig);
            end
            if (slot == G) glitch = 8'h00;
        end
        if (ld) begin
            m_shv  = v;
            m_shdp = dp;
        end
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic en);
        repeat (n) step(en, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("an_o", 32'(an_o), 32'(e.an));
                chk("frame_tick", 32'(frame_tick), 32'(e.tick));
                if (e.chk_seg) chk("seg_o", 32'(seg_o), 32'(e.seg));
                if (e.chk_nib) chk("nibble_o", 32'(nibble_o), 32'(e.nib));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int drop;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_an", 32'(an_o), 32'hF);
        chk("reset_seg", 32'(seg_o), 32'hFF);
        chk("reset_nib", 32'(nibble_o), 32'h0);
        chk("reset_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 12AF loaded while idle, then two full frames.
        step(1'b0, 1'b1, 16'h12AF, 4'h0);
        run(2 * FRAME, 1'b1);

        // Mid-frame load only takes effect at the next frame.
        run(16, 1'b1);
        step(1'b1, 1'b1, 16'h0003, 4'h0);
        run(2 * FRAME, 1'b1);

        step(1'b1, 1'b1, 16'h8888, 4'b0100);
        run(2 * FRAME, 1'b1);

        // Drop enable during digit 2 ON, then resume.
        for (int k = 0; k < FRAME && m_t != 2 * DPER + 4; k++) run(1, 1'b1);
        run(3, 1'b0);
        run(FRAME + 5, 1'b1);

        // Asynchronous reset in the middle of digit 1 ON.
        for (int k = 0; k < FRAME && m_t != DPER + 3; k++) run(1, 1'b1);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        #1;
        chk("async_rst_an", 32'(an_o), 32'hF);
        chk("async_rst_seg", 32'(seg_o), 32'hFF);
        chk("async_rst_tick", 32'(frame_tick), 32'h0);
        chk("async_rst_nib", 32'(nibble_o), 32'h0);
        m_run = 1'b0; m_t = 0; m_shv = '0; m_av = '0; m_shdp = '0; m_adp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run(3, 1'b0);
        run(FRAME + 5, 1'b1);

        // Load exactly on the frame-start edge.
        for (int k = 0; k < FRAME && m_t != FRAME - 1; k++) run(1, 1'b1);
        step(1'b1, 1'b1, 16'hBEEF, 4'h0);
        run(FRAME, 1'b1);

        drop = 0;
        repeat (1200) begin
            if (drop > 0) drop--;
            else if ($urandom_range(0, 199) == 0) drop = $urandom_range(1, 3);
            step(drop == 0, $urandom_range(0, 11) == 0,
                 16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for an NUM_DIGITS-digit, common-anode, active-low 7-segment display. It sequences one shared combinational hex-to-segment decoder (4-bit nibble in, 8-bit active-low segments out, bit 7 = dp) across all digits. It inserts a blanking guard between digits against ghosting and double-buffers the displayed value so a frame never tears. It sits between the status/debug logic that owns the value and the board display pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 50000, clock cycles each digit is lit (>=2)
- GUARD_CYCLES, 16, clock cycles all anodes are off before each digit (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  scan enable; low blanks the display
- load  input  1  single-cycle strobe; captures value/dp_mask into shadow registers
- value  input  4*NUM_DIGITS  hex digits; digit 0 = value[3:0] = rightmost
- dp_mask  input  NUM_DIGITS  1 = light decimal point of that digit
- nibble_o  output  4  nibble driven to the shared decoder
- seg_i  input  8  decoded active-low segments returned by the decoder (combinational from nibble_o)
- seg_o  output  8  registered active-low segments to pins
- an_o  output  NUM_DIGITS  registered active-low anode enables
- frame_tick  output  1  one-cycle pulse at the start of each frame

## Operation
- States: IDLE, GUARD, ON. Digit index d: $clog2(NUM_DIGITS) bits. Cycle counter: wide enough for max(REFRESH_DIV, GUARD_CYCLES).
- IDLE: an_o all 1, seg_o 8'hFF, d=0. On an edge with enable=1, go to GUARD with d=0.
- GUARD: an_o all 1, nibble_o = active digit d. After GUARD_CYCLES cycles, go to ON.
- ON: an_o[d]=0, others 1; seg_o = seg_i captured on the ON-entry edge, with bit 7 forced 0 if active dp_mask[d]=1. After REFRESH_DIV cycles, go to GUARD with d+1; d wraps NUM_DIGITS-1 -> 0.
- Frame start = each GUARD entry with d=0. On that edge: active_value/active_dp <= shadow; frame_tick=1 for that cycle.
- load: shadow <= value/dp_mask. If load coincides with a frame-start edge, value/dp_mask bypass the shadow into active directly. Multiple loads within a frame: the last one wins.
- enable low in any state: the next edge goes to IDLE (anodes off immediately), counter cleared, d=0. Re-enable restarts at digit 0 with a frame_tick.
- seg_i is only sampled on the ON-entry edge; glitches on seg_i at other times have no effect.

## Timing
- Reset values: an_o all 1, seg_o 8'hFF, nibble_o 4'h0, frame_tick 0, state IDLE, d 0, counter 0, shadow/active value 0, dp 0.
- Edge E0 samples enable=1: GUARD entered, frame_tick high in cycle after E0. an_o[0] falls at E0+GUARD_CYCLES.
- Digit period = GUARD_CYCLES+REFRESH_DIV. Frame period = NUM_DIGITS*(GUARD_CYCLES+REFRESH_DIV).
- Latency from load to pins: at most one frame period plus GUARD_CYCLES.
- No overlap: at most one an_o bit is low in any cycle, and all are high for GUARD_CYCLES between digits.
- Reset asserted mid-scan: outputs go to reset values asynchronously. After release, operation resumes from IDLE.

## Configuration
- LEADING_ZERO_BLANK_EN defined: at frame start, every digit above the highest nonzero nibble of active_value is blanked. Blanked means its ON phase still occurs with the same timing, but seg_o=8'hFF, and its dp is still honoured. Digit 0 is never blanked (value 0 shows "0").
- Undefined: all digits are displayed, including leading zeros.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, with the team's hex decoder connected between nibble_o and seg_i.
- Reset, then enable=1, with load of value 16'h12AF: an_o sequence 1110,1101,1011,0111 with 2-cycle 1111 gaps. seg_o = 8E, 88, A4, F9. Frame period is 40 cycles and frame_tick has a 40-cycle spacing.
- load 16'h0003 mid-frame: the remaining digits of the current frame are unchanged, and the new value appears from the next frame_tick. With LEADING_ZERO_BLANK_EN, digits 1..3 show FF and digit 0 shows B0. Without it, digits 1..3 show C0.
- Set dp_mask=4'b0100, value 16'h8888: digit 2 shows 8'h00 and all other digits show 8'h80.
- Drop enable during digit 2 ON: the next cycle has an_o=1111 and seg_o=FF. Re-enable: frame_tick pulses, and digit 0 lights after 2 cycles.
- Assert rst_n low mid-ON: an_o=1111 and seg_o=FF without a clock edge. After release, state is IDLE and active_value is 0.
- Assert load on the frame-start edge with value 16'hBEEF: that same frame displays BEEF.
